// File: rtl/cordic_pkg.sv
// Shared definitions for the iterative CORDIC engine: mode encoding, FSM states,
// and constant generators for the arctangent table and the gain-compensation factor.
package cordic_pkg;

  localparam logic MODE_ROT = 1'b0;
  localparam logic MODE_VEC = 1'b1;

  // Counter wide enough for the largest legal ITER (24).
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_COMP = 2'd2,
    ST_DONE = 2'd3
  } cordic_state_e;

  // atan(2^-i) scaled by 2^30, rounded; beyond i=10 it equals 2^(30-i) at this precision.
  function automatic longint atan_base(input int i);
    case (i)
      0:       return 64'd843314857;
      1:       return 64'd497837829;
      2:       return 64'd263043837;
      3:       return 64'd133525159;
      4:       return 64'd67021687;
      5:       return 64'd33543516;
      6:       return 64'd16775851;
      7:       return 64'd8388437;
      8:       return 64'd4194283;
      9:       return 64'd2097149;
      default: return longint'(1) << (30 - i);
    endcase
  endfunction

  // round(atan(2^-i) * 2^(width-3))
  function automatic longint atan_q(input int i, input int width);
    longint t = atan_base(i);
    int     f = width - 3;
    if (f >= 30) return t << (f - 30);
    return (t + (longint'(1) << (29 - f))) >>> (30 - f);
  endfunction

  // round(0.6072529 * 2^(width-1)); 652032836 is that factor scaled by 2^30.
  function automatic longint k_q(input int width);
    longint k30 = 64'd652032836;
    int     f   = width - 1;
    if (f >= 30) return k30 << (f - 30);
    return (k30 + (longint'(1) << (29 - f))) >>> (30 - f);
  endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent lookup, one entry per micro-rotation, Q3.(WIDTH-3) radians.
module cordic_atan_rom
  import cordic_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ITER  = 14
) (
  input  logic        [CNT_W-1:0] idx,
  output logic signed [WIDTH-1:0] atan_val
);

  always_comb begin
    atan_val = '0;
    for (int k = 0; k < ITER; k++) begin
      if (idx == CNT_W'(k)) atan_val = WIDTH'(atan_q(k, WIDTH));
    end
  end

endmodule

// File: rtl/cordic_iter_core.sv
// Iterative CORDIC engine: one micro-rotation per clock, rotation or vectoring mode.
// Define CORDIC_GAIN_COMP_EN to add a one-cycle gain compensation step (unit-gain outputs).
module cordic_iter_core
  import cordic_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ITER  = 14
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    mode,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic signed [WIDTH-1:0] y_in,
  input  logic signed [WIDTH-1:0] z_in,
  output logic                    in_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH+1:0] x_out,
  output logic signed [WIDTH+1:0] y_out,
  output logic signed [WIDTH-1:0] z_out
);

  localparam int DW       = WIDTH + 2;
  localparam int ITER_MAX = (WIDTH - 1 < 24) ? WIDTH - 1 : 24;

  if (ITER < 1 || ITER > ITER_MAX) begin : g_bad_iter
    $error("cordic_iter_core: ITER must lie in 1..min(WIDTH-1,24)");
  end

  // Handshake: a request is taken when start && in_ready (IDLE only); a result is
  // consumed when out_valid && out_ready, and out_valid holds with stable data until then.

  cordic_state_e           state, state_nxt;
  logic        [CNT_W-1:0] iter_cnt;
  logic                    mode_q;
  logic                    ready_en;
  logic signed [DW-1:0]    x_q, y_q;
  logic signed [WIDTH-1:0] z_q;
  logic signed [WIDTH-1:0] atan_val;
  logic signed [DW-1:0]    x_sh, y_sh, x_nxt, y_nxt;
  logic signed [WIDTH-1:0] z_nxt;
  logic                    d_pos;
  logic                    last_iter;
  logic                    accept;

  cordic_atan_rom #(.WIDTH(WIDTH), .ITER(ITER)) u_atan_rom (
    .idx      (iter_cnt),
    .atan_val (atan_val)
  );

  // ready_en keeps in_ready low until the first clock after reset release.
  assign in_ready  = (state == ST_IDLE) && ready_en;
  assign accept    = start && in_ready;
  assign last_iter = (iter_cnt == CNT_W'(ITER - 1));

  // d = +1 when z >= 0 (rotation) or y < 0 (vectoring)
  always_comb begin
    d_pos = (mode_q == MODE_VEC) ? y_q[DW-1] : ~z_q[WIDTH-1];
    x_sh  = x_q >>> iter_cnt;
    y_sh  = y_q >>> iter_cnt;
    x_nxt = d_pos ? (x_q - y_sh) : (x_q + y_sh);
    y_nxt = d_pos ? (y_q + x_sh) : (y_q - x_sh);
    z_nxt = d_pos ? (z_q - atan_val) : (z_q + atan_val);
  end

`ifdef CORDIC_GAIN_COMP_EN
  localparam logic signed [WIDTH:0] KQ = (WIDTH + 1)'(k_q(WIDTH));
  localparam int PW = DW + WIDTH + 1;
  logic signed [PW-1:0] x_prod, y_prod;
  logic signed [DW-1:0] x_comp, y_comp;
  always_comb begin
    x_prod = PW'(x_q) * PW'(KQ);
    y_prod = PW'(y_q) * PW'(KQ);
    x_comp = DW'(x_prod >>> (WIDTH - 1));
    y_comp = DW'(y_prod >>> (WIDTH - 1));
  end
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_RUN;
      ST_RUN: begin
        if (last_iter) begin
`ifdef CORDIC_GAIN_COMP_EN
          state_nxt = ST_COMP;
`else
          state_nxt = ST_DONE;
`endif
        end
      end
      ST_COMP: state_nxt = ST_DONE;
      ST_DONE: if (out_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      iter_cnt  <= '0;
      mode_q    <= MODE_ROT;
      ready_en  <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      x_out     <= '0;
      y_out     <= '0;
      z_out     <= '0;
      out_valid <= 1'b0;
    end else begin
      state    <= state_nxt;
      ready_en <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            x_q      <= DW'(x_in);
            y_q      <= DW'(y_in);
            z_q      <= z_in;
            mode_q   <= mode;
            iter_cnt <= '0;
          end
        end
        ST_RUN: begin
          x_q      <= x_nxt;
          y_q      <= y_nxt;
          z_q      <= z_nxt;
          iter_cnt <= iter_cnt + CNT_W'(1);
          if (last_iter) begin
            iter_cnt <= '0;
`ifndef CORDIC_GAIN_COMP_EN
            // Outputs load only from a finished result, never mid-iteration.
            x_out     <= x_nxt;
            y_out     <= y_nxt;
            z_out     <= z_nxt;
            out_valid <= 1'b1;
`endif
          end
        end
        ST_COMP: begin
`ifdef CORDIC_GAIN_COMP_EN
          x_out     <= x_comp;
          y_out     <= y_comp;
          z_out     <= z_q;
          out_valid <= 1'b1;
`endif
        end
        ST_DONE: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_iter_core.sv
// Self-checking bench for cordic_iter_core: vector table, random rotations,
// DONE back-pressure with ignored starts, and reset during RUN.
module tb_cordic_iter_core;

  localparam int  WIDTH    = 16;
  localparam int  ITER     = 14;
  localparam int  DW       = WIDTH + 2;
  localparam real GAIN_RAW = 1.6467602;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int  LAT      = ITER + 2;
  localparam real GAIN_ADJ = 0.6072529;
`else
  localparam int  LAT      = ITER + 1;
  localparam real GAIN_ADJ = 1.0;
`endif

  logic                    clk;
  logic                    rst;
  logic                    start;
  logic                    mode;
  logic signed [WIDTH-1:0] x_in, y_in, z_in;
  logic                    in_ready;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [DW-1:0]    x_out, y_out;
  logic signed [WIDTH-1:0] z_out;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic signed [DW-1:0]    x;
    logic signed [DW-1:0]    y;
    logic signed [WIDTH-1:0] z;
    logic        [7:0]       tx;
    logic        [7:0]       ty;
    logic        [7:0]       tz;
  } exp_t;
  localparam int EXP_W = $bits(exp_t);
  logic [EXP_W-1:0] exp_q[$];

  // Expected values are in raw-gain units; unit-gain builds scale them by K.
  typedef struct {
    logic mode;
    int   x, y, z;
    int   ex, ey, ez;
    int   tx, ty, tz;
  } vec_t;
  vec_t vecs[9];

  cordic_iter_core #(.WIDTH(WIDTH), .ITER(ITER)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .x_in      (x_in),
    .y_in      (y_in),
    .z_in      (z_in),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x_out     (x_out),
    .y_out     (y_out),
    .z_out     (z_out)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic int round_i(input real v);
    if (v >= 0.0) return $rtoi(v + 0.5);
    return -$rtoi(0.5 - v);
  endfunction

  task automatic chk(input string name, input longint act, input longint exp, input longint tol);
    longint d;
    d = act - exp;
    if (d < 0) d = -d;
    checks++;
    if (d > tol) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d tol=%0d", name, act, exp, tol);
    end
  endtask

  task automatic push_exp(input real ex, input real ey, input int ez,
                          input int tx, input int ty, input int tz);
    exp_t e;
    e.x  = DW'(round_i(ex * GAIN_ADJ));
    e.y  = DW'(round_i(ey * GAIN_ADJ));
    e.z  = WIDTH'(ez);
    e.tx = 8'(tx);
    e.ty = 8'(ty);
    e.tz = 8'(tz);
    exp_q.push_back(e);
  endtask

  // driver tasks: entered and left #1 after a rising edge
  task automatic send(input logic m, input int xi, input int yi, input int zi);
    int guard;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("accept_ready", in_ready, 1, 0);
    start = 1'b1;
    mode  = m;
    x_in  = WIDTH'(xi);
    y_in  = WIDTH'(yi);
    z_in  = WIDTH'(zi);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 1;
    while (!out_valid && n < LAT + 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, n, LAT, 0);
  endtask

  task automatic check_result(input string name);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s_queue actual=empty required=entry", name);
    end else begin
      e = exp_t'(exp_q.pop_front());
      chk({name, "_x"}, x_out, e.x, e.tx);
      chk({name, "_y"}, y_out, e.y, e.ty);
      chk({name, "_z"}, z_out, e.z, e.tz);
    end
  endtask

  task automatic release_result(input string name);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({name, "_valid_drop"}, out_valid, 0, 0);
    chk({name, "_idle_ready"}, in_ready, 1, 0);
  endtask

  initial begin
    logic signed [DW-1:0]    hx, hy;
    logic signed [WIDTH-1:0] hz;
    int rx, rz;
    real zr;

    vecs[0] = '{1'b0,  9949,      0,   6434, 11585,  11585,     0, 5, 5, 2};
    vecs[1] = '{1'b0,  9949,      0,      0, 16384,      0,     0, 5, 5, 2};
    vecs[2] = '{1'b0,  9949,      0,  -6434, 11585, -11585,     0, 5, 5, 2};
    vecs[3] = '{1'b0,  9949,      0,  12868,     0,  16384,     0, 5, 5, 2};
    vecs[4] = '{1'b0,     0,   9949,  -6434, 11585,  11585,     0, 5, 5, 2};
    vecs[5] = '{1'b1, 16384,  16384,      0, 38158,      0,  6434, 8, 4, 4};
    vecs[6] = '{1'b1, 16384, -16384,      0, 38158,      0, -6434, 8, 4, 4};
    vecs[7] = '{1'b1, 16384,      0,      0, 26980,      0,     0, 8, 4, 4};
    vecs[8] = '{1'b1, 16384,   8192,    100, 30165,      0,  3898, 8, 4, 4};

    rst = 1'b1; start = 1'b0; mode = 1'b0; out_ready = 1'b0;
    x_in = '0; y_in = '0; z_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_x_out", x_out, 0, 0);
    chk("rst_y_out", y_out, 0, 0);
    chk("rst_z_out", z_out, 0, 0);
    chk("rst_out_valid", out_valid, 0, 0);
    rst = 1'b0;
    #1;
    chk("rst_release_in_ready_low", in_ready, 0, 0);
    @(posedge clk); #1;
    chk("rst_release_in_ready_high", in_ready, 1, 0);

    // table-driven vectors
    for (int i = 0; i < 9; i++) begin
      push_exp(real'(vecs[i].ex), real'(vecs[i].ey), vecs[i].ez,
               vecs[i].tx, vecs[i].ty, vecs[i].tz);
      send(vecs[i].mode, vecs[i].x, vecs[i].y, vecs[i].z);
      wait_valid($sformatf("vec%0d_latency", i));
      check_result($sformatf("vec%0d", i));
      release_result($sformatf("vec%0d", i));
    end

    // random rotations, out_ready held high while busy (no effect before out_valid)
    for (int i = 0; i < 6; i++) begin
      rx = int'($urandom_range(4000, 9949));
      rz = int'($urandom_range(0, 24000)) - 12000;
      zr = real'(rz) / 8192.0;
      push_exp(real'(rx) * $cos(zr) * GAIN_RAW, real'(rx) * $sin(zr) * GAIN_RAW, 0, 8, 8, 2);
      out_ready = 1'b1;
      send(1'b0, rx, 0, rz);
      wait_valid($sformatf("rnd%0d_latency", i));
      check_result($sformatf("rnd%0d", i));
      release_result($sformatf("rnd%0d", i));
    end

    // back-pressure in DONE: outputs stable, starts ignored
    push_exp(11585.0, 11585.0, 0, 5, 5, 2);
    send(1'b0, 9949, 0, 6434);
    wait_valid("hold_latency");
    hx = x_out; hy = y_out; hz = z_out;
    for (int k = 0; k < 10; k++) begin
      start = (k % 3 == 0);
      mode  = 1'b1;
      x_in  = WIDTH'(int'($urandom_range(0, 16000)));
      y_in  = WIDTH'(int'($urandom_range(0, 16000)));
      @(posedge clk); #1;
      chk($sformatf("hold%0d_stable", k), ((x_out == hx) && (y_out == hy) && (z_out == hz)), 1, 0);
      chk($sformatf("hold%0d_in_ready", k), in_ready, 0, 0);
      chk($sformatf("hold%0d_valid", k), out_valid, 1, 0);
    end
    start = 1'b0;
    check_result("hold");
    // start coinciding with out_ready in DONE is dropped
    start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; out_ready = 1'b0;
    chk("drop_valid", out_valid, 0, 0);
    chk("drop_in_ready", in_ready, 1, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("drop_not_queued", in_ready, 1, 0);
    chk("drop_no_result", out_valid, 0, 0);

    // reset during RUN iteration 5
    send(1'b0, 9949, 0, 6434);
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("abort_x_out", x_out, 0, 0);
    chk("abort_y_out", y_out, 0, 0);
    chk("abort_z_out", z_out, 0, 0);
    chk("abort_out_valid", out_valid, 0, 0);
    chk("abort_in_ready", in_ready, 0, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_release_in_ready", in_ready, 1, 0);
    chk("abort_release_valid", out_valid, 0, 0);
    push_exp(16384.0, 0.0, 0, 5, 5, 2);
    send(1'b0, 9949, 0, 0);
    wait_valid("after_abort_latency");
    check_result("after_abort");
    release_result("after_abort");

    chk("queue_empty", exp_q.size(), 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
